// File: rtl/rvfi_reorder.sv
// ---------------------------------------------------------------------------
// rvfi_reorder
//   Restores program order for RVFI retirement packets that may arrive out of
//   order. Packets are tagged with rvfi_order. A packet equal to the expected
//   order is forwarded straight to the outputs. A packet up to DEPTH-1 ahead
//   is parked in a slot until its turn. Anything else is dropped and flagged.
//
// Ports
//   clock       : single clock, rising edge
//   reset       : synchronous, active-high
//   in_valid    : retirement packet present (no back-pressure)
//   in_order    : rvfi_order of incoming packet
//   in_data     : opaque payload of incoming packet
//   out_valid   : in-order packet emitted this cycle
//   out_order   : rvfi_order of emitted packet (holds when out_valid=0)
//   out_data    : payload of emitted packet (holds when out_valid=0)
//   occupancy   : number of parked packets
//   err_window  : sticky, a packet fell outside the acceptance window
//   err_dup     : sticky, a packet targeted an already occupied slot
// ---------------------------------------------------------------------------
module rvfi_reorder #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 128
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [63:0]              in_order,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    output logic [63:0]              out_order,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err_window,
    output logic                     err_dup
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    logic [63:0]        r_next_order;
    logic [DEPTH-1:0]   r_valid;
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic               r_out_valid;
    logic [63:0]        r_out_order;
    logic [DATA_W-1:0]  r_out_data;
    logic [OCC_W-1:0]   r_occ;
    logic               r_err_window;
    logic               r_err_dup;

    logic [63:0]        w_diff;
    logic               w_in_win;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_head;
    logic               w_dup;
    logic               w_accept;
    logic               w_bypass;
    logic               w_store;
    logic               w_drain;

    // Modular distance from the expected order; wraps naturally at 2^64, so
    // packets "behind" next_order appear as huge distances and fail the window.
    assign w_diff   = in_order - r_next_order;
    assign w_in_win = (w_diff < 64'(DEPTH));
    assign w_idx    = in_order[IDX_W-1:0];
    assign w_head   = r_next_order[IDX_W-1:0];

    // Duplicate detection precedes bypass: a head packet whose slot is already
    // parked (not yet drained) is a duplicate, not a second bypass.
    assign w_dup    = in_valid && w_in_win && r_valid[w_idx];
    assign w_accept = in_valid && w_in_win && !r_valid[w_idx];
    assign w_bypass = w_accept && (w_diff == 64'd0);
    assign w_store  = w_accept && !w_bypass;
    // Bypass owns the output register this cycle; drain waits one cycle.
    // A store never targets the head slot (diff >= 1), so drain+store coexist.
    assign w_drain  = !w_bypass && r_valid[w_head];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_next_order <= 64'd0;
            r_valid      <= '0;
            r_out_valid  <= 1'b0;
            r_out_order  <= 64'd0;
            r_out_data   <= '0;
            r_occ        <= '0;
            r_err_window <= 1'b0;
            r_err_dup    <= 1'b0;
        end else begin
            if (w_bypass || w_drain)
                r_next_order <= r_next_order + 64'd1;
            if (w_drain)
                r_valid[w_head] <= 1'b0;
            if (w_store)
                r_valid[w_idx] <= 1'b1;

            r_out_valid <= w_bypass || w_drain;
            if (w_bypass) begin
                r_out_order <= in_order;
                r_out_data  <= in_data;
            end else if (w_drain) begin
                r_out_order <= r_next_order;
                r_out_data  <= r_data[w_head];
            end

            r_occ <= r_occ + OCC_W'(w_store) - OCC_W'(w_drain);

            if (in_valid && !w_in_win)
                r_err_window <= 1'b1;
            if (w_dup)
                r_err_dup <= 1'b1;
        end
    end

    // Payload storage needs no reset; validity is tracked by r_valid.
    always_ff @(posedge clock) begin
        if (!reset && w_store)
            r_data[w_idx] <= in_data;
    end

    assign out_valid  = r_out_valid;
    assign out_order  = r_out_order;
    assign out_data   = r_out_data;
    assign occupancy  = r_occ;
    assign err_window = r_err_window;
    assign err_dup    = r_err_dup;

endmodule

// File: tb/tb_rvfi_reorder.sv
// ---------------------------------------------------------------------------
// tb_rvfi_reorder
//   Scoreboard bench for rvfi_reorder (DEPTH=4, DATA_W=128). Each scenario
//   queues the expected emissions in order; an output monitor pops and
//   compares every out_valid beat. Scenario tasks check occupancy, flags and
//   out_valid timing inline.
// ---------------------------------------------------------------------------
module tb_rvfi_reorder;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 128;
    localparam logic [63:0] MAXO = 64'hFFFF_FFFF_FFFF_FFFF;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [63:0]       in_order;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [63:0]       out_order;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        occupancy;
    logic              err_window;
    logic              err_dup;

    typedef struct {
        logic [63:0]       ord;
        logic [DATA_W-1:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    rvfi_reorder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_order(in_order), .in_data(in_data),
        .out_valid(out_valid), .out_order(out_order), .out_data(out_data),
        .occupancy(occupancy), .err_window(err_window), .err_dup(err_dup)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] pay(input logic [63:0] o, input logic [7:0] salt);
        return {o ^ {8{salt}}, ~o};
    endfunction

    function automatic exp_t mk(input logic [63:0] o, input logic [DATA_W-1:0] d);
        exp_t e;
        e.ord = o;
        e.dat = d;
        return e;
    endfunction

    // Apply inputs (caller is at a negedge) and advance to the next negedge,
    // where outputs from the intervening posedge are stable.
    task automatic cyc(input logic v, input logic [63:0] o, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_order = o;
        in_data  = d;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
    endtask

    // Output monitor: every emission must match the head of the scoreboard.
    always @(negedge clock) begin
        if (out_valid === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_emit got order %0h want none", out_order);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_order !== e.ord || out_data !== e.dat)
                    $display("FAIL emit got order %0h data %0h want order %0h data %0h",
                             out_order, out_data, e.ord, e.dat);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b1, 64'd0, pay(64'd0, 8'h11));  // ignored while reset
        cyc(1'b0, 64'd0, '0);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", out_valid); else n_pass++;
        n_chk++; if (occupancy !== 3'd0) $display("FAIL rst_occ got %0d want 0", occupancy); else n_pass++;
        n_chk++; if (err_window !== 1'b0 || err_dup !== 1'b0)
            $display("FAIL rst_err got %0b%0b want 00", err_window, err_dup); else n_pass++;
        n_chk++; if (out_order !== 64'd0 || out_data !== '0)
            $display("FAIL rst_outs got %0h/%0h want 0/0", out_order, out_data); else n_pass++;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_in_order();
        do_reset();
        for (int i = 0; i < 3; i++) sb.push_back(mk(64'(i), pay(64'(i), 8'h21)));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 64'(i), pay(64'(i), 8'h21));
            n_chk++; if (out_valid !== 1'b1) $display("FAIL inord_valid%0d got %0b want 1", i, out_valid); else n_pass++;
            n_chk++; if (occupancy !== 3'd0) $display("FAIL inord_occ%0d got %0d want 0", i, occupancy); else n_pass++;
        end
        cyc(1'b0, 64'd0, '0);
        n_chk++; if (out_valid !== 1'b0) $display("FAIL inord_idle got %0b want 0", out_valid); else n_pass++;
        #1;
        n_chk++; if (sb.size() != 0) $display("FAIL inord_pending got %0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_reorder();
        logic [63:0] ord_in [4];
        logic [2:0]  occ_exp [8];
        logic        vld_exp [8];
        ord_in  = '{64'd2, 64'd1, 64'd3, 64'd0};
        occ_exp = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        vld_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) sb.push_back(mk(64'(i), pay(64'(i), 8'h32)));
        for (int c = 0; c < 8; c++) begin
            if (c < 4) cyc(1'b1, ord_in[c], pay(ord_in[c], 8'h32));
            else       cyc(1'b0, 64'd0, '0);
            n_chk++; if (occupancy !== occ_exp[c]) $display("FAIL reord_occ%0d got %0d want %0d", c, occupancy, occ_exp[c]); else n_pass++;
            n_chk++; if (out_valid !== vld_exp[c]) $display("FAIL reord_valid%0d got %0b want %0b", c, out_valid, vld_exp[c]); else n_pass++;
        end
        n_chk++; if (out_order !== 64'd3 || out_data !== pay(64'd3, 8'h32))
            $display("FAIL reord_hold got %0h want 3", out_order); else n_pass++;
        #1;
        n_chk++; if (sb.size() != 0) $display("FAIL reord_pending got %0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_window();
        do_reset();
        cyc(1'b1, 64'd4, pay(64'd4, 8'h43));
        n_chk++; if (err_window !== 1'b1) $display("FAIL win_flag got %0b want 1", err_window); else n_pass++;
        n_chk++; if (occupancy !== 3'd0) $display("FAIL win_occ got %0d want 0", occupancy); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL win_valid got %0b want 0", out_valid); else n_pass++;
        sb.push_back(mk(64'd0, pay(64'd0, 8'h43)));
        cyc(1'b1, 64'd0, pay(64'd0, 8'h43));
        // packet behind the window (order below next_order)
        cyc(1'b1, 64'd0, pay(64'd0, 8'h44));
        cyc(1'b0, 64'd0, '0);
        n_chk++; if (err_window !== 1'b1 || err_dup !== 1'b0)
            $display("FAIL win_sticky got %0b%0b want 10", err_window, err_dup); else n_pass++;
        #1;
        n_chk++; if (sb.size() != 0) $display("FAIL win_pending got %0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_dup();
        do_reset();
        cyc(1'b1, 64'd2, pay(64'd2, 8'h51));
        cyc(1'b1, 64'd2, pay(64'd2, 8'h52));
        n_chk++; if (err_dup !== 1'b1) $display("FAIL dup_flag got %0b want 1", err_dup); else n_pass++;
        n_chk++; if (occupancy !== 3'd1) $display("FAIL dup_occ got %0d want 1", occupancy); else n_pass++;
        n_chk++; if (err_window !== 1'b0) $display("FAIL dup_win got %0b want 0", err_window); else n_pass++;
        sb.push_back(mk(64'd0, pay(64'd0, 8'h53)));
        sb.push_back(mk(64'd1, pay(64'd1, 8'h53)));
        sb.push_back(mk(64'd2, pay(64'd2, 8'h51)));
        cyc(1'b1, 64'd0, pay(64'd0, 8'h53));
        cyc(1'b1, 64'd1, pay(64'd1, 8'h53));
        cyc(1'b0, 64'd0, '0);
        cyc(1'b0, 64'd0, '0);
        n_chk++; if (occupancy !== 3'd0) $display("FAIL dup_drain_occ got %0d want 0", occupancy); else n_pass++;
        #1;
        n_chk++; if (sb.size() != 0) $display("FAIL dup_pending got %0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        // Preload the expected order near the 64-bit limit on an idle cycle.
        force dut.r_next_order = MAXO - 64'd1;
        cyc(1'b0, 64'd0, '0);
        release dut.r_next_order;
        sb.push_back(mk(MAXO - 64'd1, pay(MAXO - 64'd1, 8'h61)));
        sb.push_back(mk(MAXO, pay(MAXO, 8'h61)));
        sb.push_back(mk(64'd0, pay(64'd0, 8'h61)));
        cyc(1'b1, MAXO, pay(MAXO, 8'h61));
        n_chk++; if (occupancy !== 3'd1) $display("FAIL wrap_occ got %0d want 1", occupancy); else n_pass++;
        cyc(1'b1, MAXO - 64'd1, pay(MAXO - 64'd1, 8'h61));
        cyc(1'b1, 64'd0, pay(64'd0, 8'h61));
        n_chk++; if (out_valid !== 1'b1 || occupancy !== 3'd1)
            $display("FAIL wrap_mid got %0b/%0d want 1/1", out_valid, occupancy); else n_pass++;
        cyc(1'b0, 64'd0, '0);
        n_chk++; if (out_valid !== 1'b1) $display("FAIL wrap_last got %0b want 1", out_valid); else n_pass++;
        cyc(1'b0, 64'd0, '0);
        n_chk++; if (err_window !== 1'b0 || err_dup !== 1'b0 || occupancy !== 3'd0)
            $display("FAIL wrap_end got %0b%0b/%0d want 00/0", err_window, err_dup, occupancy); else n_pass++;
        #1;
        n_chk++; if (sb.size() != 0) $display("FAIL wrap_pending got %0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        cyc(1'b1, 64'd2, pay(64'd2, 8'h71));
        cyc(1'b1, 64'd3, pay(64'd3, 8'h71));
        cyc(1'b1, 64'd2, pay(64'd2, 8'h72));
        n_chk++; if (occupancy !== 3'd2 || err_dup !== 1'b1)
            $display("FAIL mrst_pre got %0d/%0b want 2/1", occupancy, err_dup); else n_pass++;
        reset = 1'b1;
        cyc(1'b1, 64'd0, pay(64'd0, 8'h73));  // ignored while reset
        reset = 1'b0;
        sb.delete();
        n_chk++; if (occupancy !== 3'd0) $display("FAIL mrst_occ got %0d want 0", occupancy); else n_pass++;
        n_chk++; if (err_dup !== 1'b0 || err_window !== 1'b0)
            $display("FAIL mrst_err got %0b%0b want 00", err_window, err_dup); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL mrst_valid got %0b want 0", out_valid); else n_pass++;
        sb.push_back(mk(64'd0, pay(64'd0, 8'h74)));
        cyc(1'b1, 64'd0, pay(64'd0, 8'h74));
        // discarded slots 2/3 must not drain after order 1 is skipped
        cyc(1'b0, 64'd0, '0);
        cyc(1'b0, 64'd0, '0);
        n_chk++; if (occupancy !== 3'd0) $display("FAIL mrst_after got %0d want 0", occupancy); else n_pass++;
        #1;
        n_chk++; if (sb.size() != 0) $display("FAIL mrst_pending got %0d want 0", sb.size()); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_order = '0;
        in_data  = '0;
        @(negedge clock);
        test_reset();
        test_in_order();
        test_reorder();
        test_window();
        test_dup();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
